data_mem_dumper: RTL and testbench



---
 rtl/data_mem_dumper.sv | 130 +++++++++++++
 tb/tb_data_mem_dumper.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dumper.sv
// Streams N_DATOS data-memory words out as UART bytes, low byte first.
// Optional DUMP_HEADER_EN prefixes the stream with an 8'hA5 marker byte.
module data_mem_dumper #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11,
  parameter int N_DATOS = 8,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_mem_rd,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [3:0] {
    IDLE,
`ifdef DUMP_HEADER_EN
    HDR,
    HDR_WAIT,
`endif
    RD,
    LATCH,
    TX_LO,
    WAIT_LO,
    TX_HI,
    WAIT_HI,
    DONE
  } state_e;

  localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(N_DATOS - 1);

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] idx_q, idx_d;
  logic [NB_DATA-1:0] word_q, word_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    o_mem_addr = '0;
    o_mem_rd   = 1'b0;
    o_tx_data  = '0;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          idx_d = '0;
`ifdef DUMP_HEADER_EN
          state_d = HDR;
`else
          state_d = RD;
`endif
        end
      end
`ifdef DUMP_HEADER_EN
      HDR: begin
        o_tx_data  = NB_BYTE'(8'hA5);
        o_tx_start = 1'b1;
        state_d    = HDR_WAIT;
      end
      HDR_WAIT: begin
        o_tx_data = NB_BYTE'(8'hA5);
        if (i_tx_done) state_d = RD;
      end
`endif
      RD: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = idx_q;
        state_d    = LATCH;
      end
      // memory output is registered: data valid the cycle after RD
      LATCH: begin
        word_d  = i_mem_data;
        state_d = TX_LO;
      end
      TX_LO: begin
        o_tx_data  = word_q[NB_BYTE-1:0];
        o_tx_start = 1'b1;
        state_d    = WAIT_LO;
      end
      WAIT_LO: begin
        o_tx_data = word_q[NB_BYTE-1:0];
        if (i_tx_done) state_d = TX_HI;
      end
      TX_HI: begin
        o_tx_data  = word_q[2*NB_BYTE-1:NB_BYTE];
        o_tx_start = 1'b1;
        state_d    = WAIT_HI;
      end
      WAIT_HI: begin
        o_tx_data = word_q[2*NB_BYTE-1:NB_BYTE];
        if (i_tx_done) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed self-checking bench for data_mem_dumper.
// Honours DUMP_HEADER_EN when computing the expected byte stream.
module tb_data_mem_dumper;

`ifdef DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NW = 8;
  localparam int NB = 2 * NW + HDR;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        done;

  logic        resp_done = 1'b0;
  logic        inj_done = 1'b0;
  assign tx_done = resp_done | inj_done;

  always #5 clk = ~clk;

  data_mem_dumper dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_data(mem_data), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  // single-word instance, memory constant, tx_done stuck high
  logic [10:0] addr1;
  logic        rd1, txs1, busy1, done1;
  logic [7:0]  txd1;
  logic        start1 = 1'b0;
  logic [15:0] mem1 = 16'hBEEF;
  logic        txdone1 = 1'b1;

  data_mem_dumper #(.N_DATOS(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1),
    .o_mem_addr(addr1), .o_mem_rd(rd1),
    .i_mem_data(mem1), .o_tx_data(txd1),
    .o_tx_start(txs1), .i_tx_done(txdone1),
    .o_busy(busy1), .o_done(done1)
  );

  // registered-read memory model: word k = 16'h0100 + k
  always @(posedge clk)
    if (mem_rd) mem_data <= 16'h0100 + {5'd0, mem_addr};

  // transmitter model: done pulse 3 cycles after each strobe
  int resp_cnt = 0;
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
    if (tx_start) resp_cnt = 3;
  end

  logic [7:0]  bytes_q[$];
  logic [10:0] addrs_q[$];
  int done_cnt = 0, rd_cnt = 0, addr_viol = 0, rd_run = 0, rd_long = 0;
  logic [7:0]  bytes1_q[$];
  int done1_cnt = 0;
  always @(negedge clk) begin
    if (tx_start) bytes_q.push_back(tx_data);
    if (done) done_cnt++;
    if (mem_rd) begin
      rd_cnt++;
      addrs_q.push_back(mem_addr);
      rd_run++;
      if (rd_run > 1) rd_long++;
    end else begin
      rd_run = 0;
      if (mem_addr != 0) addr_viol++;
    end
    if (txs1) bytes1_q.push_back(txd1);
    if (done1) done1_cnt++;
  end

  int tests = 0, fails = 0;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL %s timeout: done_cnt=%0d required>%0d", nm, done_cnt, d0);
    end
  endtask

  task automatic check_stream(input int b0, input string nm);
    tests++;
    if (bytes_q.size() - b0 != NB) begin
      fails++;
      $display("FAIL %s count: got %0d required %0d", nm,
               bytes_q.size() - b0, NB);
    end
    for (int i = 0; i < NB && b0 + i < bytes_q.size(); i++) begin
      logic [7:0] exp;
      int j;
      j = i - HDR;
      if (i < HDR) exp = 8'hA5;
      else if (j % 2 == 0) exp = 8'(j / 2);
      else exp = 8'h01;
      tests++;
      if (bytes_q[b0+i] !== exp) begin
        fails++;
        $display("FAIL %s byte%0d: got %h required %h", nm, i,
                 bytes_q[b0+i], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({mem_addr, mem_rd, tx_data, tx_start, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%h rd=%b txd=%h txs=%b busy=%b done=%b required all 0",
               mem_addr, mem_rd, tx_data, tx_start, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_full_dump();
    int b0, d0, r0, a0;
    b0 = bytes_q.size(); d0 = done_cnt; r0 = rd_cnt; a0 = addrs_q.size();
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    wait_done(d0, "full_dump");
    repeat (3) @(negedge clk);
    check_stream(b0, "full_dump");
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL done_pulses: got %0d required 1", done_cnt - d0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_done: got %b required 0", busy);
    end
    tests++;
    if (rd_cnt - r0 != NW) begin
      fails++;
      $display("FAIL rd_count: got %0d required %0d", rd_cnt - r0, NW);
    end
    for (int k = 0; k < NW && a0 + k < addrs_q.size(); k++) begin
      tests++;
      if (addrs_q[a0+k] !== 11'(k)) begin
        fails++;
        $display("FAIL rd_addr%0d: got %0d required %0d", k,
                 addrs_q[a0+k], k);
      end
    end
    tests++;
    if (addr_viol != 0 || rd_long != 0) begin
      fails++;
      $display("FAIL addr_when_idle/rd_width: got %0d/%0d required 0/0",
               addr_viol, rd_long);
    end
  endtask

  task automatic test_reset_mid_dump();
    int b0, d0, a0;
    b0 = bytes_q.size(); d0 = done_cnt;
    pulse_start();
    for (int c = 0; c < 2000 && bytes_q.size() - b0 < HDR + 8; c++)
      @(negedge clk);
    // TX_HI of word 3 seen; next edge enters WAIT_HI
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({mem_addr, mem_rd, tx_data, tx_start, busy, done} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: addr=%h rd=%b txd=%h txs=%b busy=%b done=%b required all 0",
               mem_addr, mem_rd, tx_data, tx_start, busy, done);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_resume: done=%0d busy=%b required %0d/0",
               done_cnt, busy, d0);
    end
    b0 = bytes_q.size(); a0 = addrs_q.size(); d0 = done_cnt;
    pulse_start();
    wait_done(d0, "restart");
    repeat (3) @(negedge clk);
    tests++;
    if (addrs_q.size() <= a0 || addrs_q[a0] !== 11'd0) begin
      fails++;
      $display("FAIL restart_addr: got %0d required 0",
               addrs_q.size() > a0 ? addrs_q[a0] : 11'h7ff);
    end
    check_stream(b0, "restart");
  endtask

  task automatic test_ignored_inputs();
    int b0, d0, k, c;
    b0 = bytes_q.size(); d0 = done_cnt; k = 0;
    pulse_start();
    for (c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(negedge clk);
      start = (c % 5 == 0);
      if (mem_rd) begin
        inj_done = 1'b1;
        k = 2;
      end else if (k > 0) begin
        k--;
        if (k == 0) inj_done = 1'b0;
      end
    end
    start = 1'b0;
    inj_done = 1'b0;
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL ignored timeout: done_cnt=%0d required>%0d", done_cnt, d0);
    end
    repeat (3) @(negedge clk);
    check_stream(b0, "ignored");
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL ignored_done: got %0d required 1", done_cnt - d0);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_word();
    int d0;
    d0 = done1_cnt;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 200 && done1_cnt == d0; c++) @(negedge clk);
    tests++;
    if (bytes1_q.size() != 2 + HDR) begin
      fails++;
      $display("FAIL single_count: got %0d required %0d",
               bytes1_q.size(), 2 + HDR);
    end
    tests++;
    if (bytes1_q.size() == 2 + HDR &&
        {bytes1_q[HDR], bytes1_q[HDR+1]} !== 16'hEFBE) begin
      fails++;
      $display("FAIL single_bytes: got %h %h required ef be",
               bytes1_q[HDR], bytes1_q[HDR+1]);
    end
    tests++;
    if (done1_cnt - d0 != 1) begin
      fails++;
      $display("FAIL single_done: got %0d required 1", done1_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_reset_mid_dump();
    test_ignored_inputs();
    test_single_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
